// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Source identifiers used by the round-robin pointer.
//   - Reset value of the round-robin pointer.
//   - Grant encoding, exposed internally so a checker can observe the winner.
// A held writeback slot is represented by its three fields (valid, rd, data).
// Those fields are carried as separate signals because their widths follow
// the DATA_W/ADDR_W parameters of the instantiating module.
package wb_arb_pkg;

  localparam logic SRC_ALU  = 1'b0;
  localparam logic SRC_MEM  = 1'b1;

  // After reset the ALU source wins the first contested round.
  localparam logic RR_RESET = SRC_ALU;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding slot for a single writeback source.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid, rd, data     incoming writeback request
//   grant               arbiter has picked this slot this cycle
//   ready               slot can accept this cycle
//   held_valid/rd/data  current slot contents
//   load                a non-zero-index request is captured at this edge
// Handshake: a transfer happens when valid & ready are both high at a
// posedge. ready never looks at valid; it only depends on reset, the slot
// occupancy and the grant, so a granted slot can refill on the same edge.
module wb_hold_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready,
  output logic              held_valid,
  output logic [ADDR_W-1:0] held_rd,
  output logic [DATA_W-1:0] held_data,
  output logic              load
);

  assign ready = ~rst & (~held_valid | grant);

  // A write to register 0 is accepted but dropped: it never occupies the slot.
  assign load = valid & ready & (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_rd    <= '0;
      held_data  <= '0;
    end else if (load) begin
      held_valid <= 1'b1;
      held_rd    <= rd;
      held_data  <= data;
    end else if (grant) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU writebacks and
// memory-load writebacks.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   alu_valid_i/alu_rd_i/alu_data_i   ALU request, alu_ready_o accept
//   mem_valid_i/mem_rd_i/mem_data_i   load request, mem_ready_o accept
//   reg_write_o/rd_index_o/wb_data_o  registered register-file write port
//   busy_mask_o                       registers with a write held or on the port
// Each source owns a one-entry slot. The grant is combinational from the held
// slots only; the winner is registered onto the port at the next edge and its
// slot is freed on that same edge.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  input  logic [ADDR_W-1:0]    alu_rd_i,
  input  logic [DATA_W-1:0]    alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 mem_valid_i,
  input  logic [ADDR_W-1:0]    mem_rd_i,
  input  logic [DATA_W-1:0]    mem_data_i,
  output logic                 mem_ready_o,
  output logic                 reg_write_o,
  output logic [ADDR_W-1:0]    rd_index_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic [2**ADDR_W-1:0] busy_mask_o
);

  localparam int NREG = 2**ADDR_W;

  logic              alu_v, mem_v;
  logic [ADDR_W-1:0] alu_rd, mem_rd;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_load, mem_load;
  logic              alu_grant, mem_grant;
  grant_e            grant;

  // rr_ptr names the source that wins the next contested round with
  // different destinations. mem_older is only meaningful while both slots
  // are held: it says the memory entry was accepted first.
  logic              rr_ptr;
  logic              mem_older;
  logic [NREG-1:0]   busy;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk        (clk_i),
    .rst        (rst_i),
    .valid      (alu_valid_i),
    .rd         (alu_rd_i),
    .data       (alu_data_i),
    .grant      (alu_grant),
    .ready      (alu_ready_o),
    .held_valid (alu_v),
    .held_rd    (alu_rd),
    .held_data  (alu_data),
    .load       (alu_load)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk        (clk_i),
    .rst        (rst_i),
    .valid      (mem_valid_i),
    .rd         (mem_rd_i),
    .data       (mem_data_i),
    .grant      (mem_grant),
    .ready      (mem_ready_o),
    .held_valid (mem_v),
    .held_rd    (mem_rd),
    .held_data  (mem_data),
    .load       (mem_load)
  );

  // Same destination: the older entry must go first so the register file
  // sees writes in acceptance order. Otherwise plain round-robin.
  always_comb begin
    grant = GNT_NONE;
    if (alu_v && mem_v) begin
      if (alu_rd == mem_rd) begin
        grant = mem_older ? GNT_MEM : GNT_ALU;
      end else begin
        grant = (rr_ptr == SRC_ALU) ? GNT_ALU : GNT_MEM;
      end
    end else if (alu_v) begin
      grant = GNT_ALU;
    end else if (mem_v) begin
      grant = GNT_MEM;
    end
  end

  assign alu_grant = (grant == GNT_ALU);
  assign mem_grant = (grant == GNT_MEM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= RR_RESET;
      mem_older   <= 1'b0;
      reg_write_o <= 1'b0;
      rd_index_o  <= '0;
      wb_data_o   <= '0;
    end else begin
      unique case (grant)
        GNT_ALU: begin
          reg_write_o <= 1'b1;
          rd_index_o  <= alu_rd;
          wb_data_o   <= alu_data;
          rr_ptr      <= SRC_MEM;
        end
        GNT_MEM: begin
          reg_write_o <= 1'b1;
          rd_index_o  <= mem_rd;
          wb_data_o   <= mem_data;
          rr_ptr      <= SRC_ALU;
        end
        default: begin
          reg_write_o <= 1'b0;
        end
      endcase

      // Age tracking: simultaneous acceptance counts the ALU entry as older.
      // A new entry is younger than whatever stays held in the other slot.
      if (alu_load && mem_load) begin
        mem_older <= 1'b0;
      end else if (alu_load && mem_v && !mem_grant) begin
        mem_older <= 1'b1;
      end else if (mem_load && alu_v && !alu_grant) begin
        mem_older <= 1'b0;
      end
    end
  end

  // Built only from registered state, so it changes on the same edges as
  // the slots and the output stage. Slots never hold index 0, but bit 0 is
  // forced low anyway so the hazard logic can rely on it.
  always_comb begin
    busy = '0;
    if (alu_v)       busy[alu_rd]     = 1'b1;
    if (mem_v)       busy[mem_rd]     = 1'b1;
    if (reg_write_o) busy[rd_index_o] = 1'b1;
    busy[0] = 1'b0;
  end

  assign busy_mask_o = busy;

endmodule
